// File: rtl/membus_arbiter_pkg.sv
// Shared types and defaults for the external memory bus arbiter.
package membus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLDW,
        GRANT,
        RELEASE,
        SLOT
    } state_e;

    localparam int unsigned OWNER_W       = 2;
    localparam int unsigned HOLD_WAIT_DEF = 2;
    localparam int unsigned MAX_BURST_DEF = 64;
    localparam int unsigned CPU_SLOT_DEF  = 4;

endpackage

// File: rtl/membus_arbiter_if.sv
// Memory bus bundle: DMA requesters, CPU side and the muxed SRAM pins.
interface membus_arbiter_if
    import membus_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = 16
) ();

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] dma_addr;
    logic [NREQ-1:0]    dma_cs;
    logic [AW-1:0]      cpu_addr;
    logic               cpu_cs;
    logic [NREQ-1:0]    gnt;
    logic               cpu_hold;
    logic [AW-1:0]      mem_addr;
    logic               mem_cs;
    logic [OWNER_W-1:0] owner;
    logic               busy;

    modport slave (
        input  req, dma_addr, dma_cs, cpu_addr, cpu_cs,
        output gnt, cpu_hold, mem_addr, mem_cs, owner, busy
    );

    modport master (
        output req, dma_addr, dma_cs, cpu_addr, cpu_cs,
        input  gnt, cpu_hold, mem_addr, mem_cs, owner, busy
    );

endinterface

// File: rtl/membus_arbiter_rr_pick.sv
// Combinational round-robin picker: first high request after ptr, wrapping.
module rr_pick
    import membus_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]    req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [NREQ-1:0]    gnt_onehot,
    output logic [OWNER_W-1:0] idx,
    output logic               any
);

    // Lowest index above ptr wins; otherwise wrap to the lowest index at or below it.
    always_comb begin
        gnt_onehot = '0;
        idx        = '0;
        any        = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!any && req[i] && (i > int'(ptr))) begin
                any           = 1'b1;
                idx           = OWNER_W'(i);
                gnt_onehot[i] = 1'b1;
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!any && req[i] && (i <= int'(ptr))) begin
                any           = 1'b1;
                idx           = OWNER_W'(i);
                gnt_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/membus_arbiter.sv
// Shares the external SRAM bus between the CPU and NREQ DMA masters with
// CPU hold-off, round-robin bounded bursts and a guaranteed CPU slot.
module membus_arbiter
    import membus_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned AW        = 16,
    parameter int unsigned HOLD_WAIT = HOLD_WAIT_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF,
    parameter int unsigned CPU_SLOT  = CPU_SLOT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    membus_arbiter_if.slave  bus
);

    localparam int unsigned BW   = $clog2(MAX_BURST + 1);
    localparam int unsigned WMAX = (HOLD_WAIT > CPU_SLOT) ? HOLD_WAIT : CPU_SLOT;
    localparam int unsigned WW   = $clog2(WMAX + 1);

    state_e             state_q, state_d;
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic [WW-1:0]      wcnt_q, wcnt_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               hold_q, hold_d;
    logic               busy_q, busy_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [OWNER_W-1:0] ptr_q, ptr_d;

    logic [NREQ-1:0]    pick_onehot;
    logic [OWNER_W-1:0] pick_idx;
    logic               pick_any;
    logic [AW-1:0]      sel_addr;
    logic               sel_cs;
    logic               sel_req;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (bus.req),
        .ptr        (ptr_q),
        .gnt_onehot (pick_onehot),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    // Per-owner view of the DMA side.
    always_comb begin
        sel_addr = '0;
        sel_cs   = 1'b0;
        sel_req  = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (owner_q == OWNER_W'(i)) begin
                sel_addr = bus.dma_addr[i*AW +: AW];
                sel_cs   = bus.dma_cs[i];
                sel_req  = bus.req[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        gnt_d   = gnt_q;
        hold_d  = hold_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = HOLDW;
                    hold_d  = 1'b1;
                    wcnt_d  = '0;
                end
            end
            HOLDW: begin
                if (wcnt_q == WW'(HOLD_WAIT - 1)) begin
                    if (pick_any) begin
                        state_d = GRANT;
                        gnt_d   = pick_onehot;
                        owner_d = pick_idx;
                        ptr_d   = pick_idx;
                        bcnt_d  = '0;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            GRANT: begin
                bcnt_d = bcnt_q + BW'(1);
                if (!sel_req || (bcnt_d == BW'(MAX_BURST))) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                end
            end
            RELEASE: begin
                state_d = SLOT;
                hold_d  = 1'b0;
                wcnt_d  = '0;
            end
            SLOT: begin
                if (wcnt_q == WW'(CPU_SLOT - 1)) begin
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                hold_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Pointer resets to NREQ-1 so requester 0 is searched first, while owner reads 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            gnt_q   <= '0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= OWNER_W'(NREQ - 1);
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // SRAM pin mux; CPU passes through whenever it owns the bus.
    always_comb begin
        bus.mem_addr = bus.cpu_addr;
        bus.mem_cs   = bus.cpu_cs;
        case (state_q)
            HOLDW, RELEASE: bus.mem_cs = 1'b0;
            GRANT: begin
                bus.mem_addr = sel_addr;
                bus.mem_cs   = sel_cs;
            end
            default: ;
        endcase
    end

    assign bus.gnt      = gnt_q;
    assign bus.cpu_hold = hold_q;
    assign bus.owner    = owner_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter: passthrough, single grant, abort,
// asynchronous reset mid-burst and round-robin bursts.
module tb_membus_arbiter;

    localparam int unsigned NREQ      = 2;
    localparam int unsigned AW        = 16;
    localparam int unsigned HOLD_WAIT = 2;
    localparam int unsigned MAX_BURST = 8;
    localparam int unsigned CPU_SLOT  = 4;

    logic clk;
    logic rst;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   hold_viol = 0;

    membus_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();

    membus_arbiter #(
        .NREQ      (NREQ),
        .AW        (AW),
        .HOLD_WAIT (HOLD_WAIT),
        .MAX_BURST (MAX_BURST),
        .CPU_SLOT  (CPU_SLOT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the next grant, then measures its length in cycles.
    task automatic next_burst(output logic [NREQ-1:0] g, output int len,
                              output int gap, output int freec);
        gap   = 0;
        freec = 0;
        len   = 0;
        while ((bus.gnt == '0) && (gap < 50)) begin
            if (!bus.cpu_hold) freec++;
            tick();
            gap++;
        end
        g = bus.gnt;
        while ((bus.gnt == g) && (g != '0) && (len < 300)) begin
            if (!bus.cpu_hold) hold_viol++;
            tick();
            len++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] g;
        int len, gap, freec, waited;
        bit saw;

        rst          = 1'b0;
        bus.req      = '0;
        bus.dma_addr = '0;
        bus.dma_cs   = '0;
        bus.cpu_addr = 16'h1234;
        bus.cpu_cs   = 1'b1;
        #2;
        check("rst_gnt",      32'(bus.gnt),      32'h0);
        check("rst_hold",     32'(bus.cpu_hold), 32'h0);
        check("rst_owner",    32'(bus.owner),    32'h0);
        check("rst_busy",     32'(bus.busy),     32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h1234);
        check("rst_mem_cs",   32'(bus.mem_cs),   32'h1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("pass_addr", 32'(bus.mem_addr), 32'h1234);
        check("pass_cs",   32'(bus.mem_cs),   32'h1);
        check("pass_busy", 32'(bus.busy),     32'h0);

        // Single request, dropped after 6 sampled-high cycles.
        bus.dma_addr = {16'h2222, 16'hABCD};
        bus.dma_cs   = 2'b11;
        bus.req      = 2'b01;
        tick();
        check("hold_latency", 32'(bus.cpu_hold), 32'h1);
        check("holdw_gnt",    32'(bus.gnt),      32'h0);
        check("holdw_cs",     32'(bus.mem_cs),   32'h0);
        check("holdw_busy",   32'(bus.busy),     32'h1);
        tick();
        check("holdw2_gnt",   32'(bus.gnt),      32'h0);
        check("holdw2_cs",    32'(bus.mem_cs),   32'h0);
        tick();
        check("grant_gnt",    32'(bus.gnt),      32'h1);
        check("grant_owner",  32'(bus.owner),    32'h0);
        check("grant_addr",   32'(bus.mem_addr), 32'hABCD);
        check("grant_cs",     32'(bus.mem_cs),   32'h1);
        tick();
        bus.dma_addr[15:0] = 16'h5555;
        #1;
        check("grant_track",  32'(bus.mem_addr), 32'h5555);
        tick();
        tick();
        check("grant_held",   32'(bus.gnt),      32'h1);
        bus.req = '0;
        tick();
        check("rel_gnt",  32'(bus.gnt),      32'h0);
        check("rel_hold", 32'(bus.cpu_hold), 32'h1);
        check("rel_cs",   32'(bus.mem_cs),   32'h0);
        check("rel_busy", 32'(bus.busy),     32'h1);
        tick();
        check("slot_hold", 32'(bus.cpu_hold), 32'h0);
        check("slot_addr", 32'(bus.mem_addr), 32'h1234);
        check("slot_cs",   32'(bus.mem_cs),   32'h1);
        len = 0;
        while (bus.busy && (len < 20)) begin
            if (bus.cpu_hold) hold_viol++;
            tick();
            len++;
        end
        check("slot_len", 32'(len), 32'd4);

        // Abort: one-cycle pulse on requester 1.
        bus.req = 2'b10;
        tick();
        bus.req = '0;
        check("abort_hold", 32'(bus.cpu_hold), 32'h1);
        saw = 1'b0;
        len = 0;
        while (bus.busy && (len < 30)) begin
            if (bus.gnt != '0) saw = 1'b1;
            tick();
            len++;
        end
        check("abort_no_gnt", 32'(saw),       32'h0);
        check("abort_len",    32'(len),       32'd7);
        check("abort_busy",   32'(bus.busy),  32'h0);
        check("abort_owner",  32'(bus.owner), 32'h0);

        // Asynchronous reset in the middle of a burst.
        bus.dma_addr = {16'h2222, 16'hABCD};
        bus.req      = 2'b01;
        tick();
        tick();
        tick();
        check("rb_gnt", 32'(bus.gnt), 32'h1);
        tick();
        tick();
        #3;
        rst = 1'b0;
        #1;
        check("ar_gnt",   32'(bus.gnt),      32'h0);
        check("ar_hold",  32'(bus.cpu_hold), 32'h0);
        check("ar_busy",  32'(bus.busy),     32'h0);
        check("ar_owner", 32'(bus.owner),    32'h0);
        check("ar_cs",    32'(bus.mem_cs),   32'h1);
        check("ar_addr",  32'(bus.mem_addr), 32'h1234);
        tick();
        rst     = 1'b1;
        bus.req = 2'b11;

        // Round-robin with both requesters held.
        next_burst(g, len, gap, freec);
        check("rr1_gnt", 32'(g),   32'h1);
        check("rr1_len", 32'(len), 32'd8);
        check("rr1_gap", 32'(gap), 32'd3);
        next_burst(g, len, gap, freec);
        check("rr2_gnt",  32'(g),     32'h2);
        check("rr2_len",  32'(len),   32'd8);
        check("rr2_gap",  32'(gap),   32'd8);
        check("rr2_free", 32'(freec), 32'd5);
        next_burst(g, len, gap, freec);
        check("rr3_gnt",  32'(g),     32'h1);
        check("rr3_len",  32'(len),   32'd8);
        check("rr3_gap",  32'(gap),   32'd8);
        check("rr3_free", 32'(freec), 32'd5);

        bus.req = '0;
        waited  = 0;
        while (bus.busy && (waited < 40)) begin
            tick();
            waited++;
        end
        check("end_busy",  32'(bus.busy),  32'h0);
        check("end_gnt",   32'(bus.gnt),   32'h0);
        check("hold_viol", 32'(hold_viol), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
